seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's BCD/hex-to-7-segment decoder.
- Monitors a multiplexed, active-high 7-segment display bus (segment lines plus one-hot digit select) and recovers the hex value shown on each digit.
- Accepts a pattern only after it has been stable for a programmable number of cycles, and flags illegal patterns.
- Used in self-checking benches and on-board loopback, where it listens to the display scanner output.

---
 rtl/seg7_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-high 7-segment bus once each (digit, pattern) pair has been stable for STABLE_CYCLES edges.
// Capture lands one edge after the run reaches STABLE_CYCLES; listen-only, so there is no backpressure.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic [3:0]          cnt_q, cnt_d;
  logic                captured_q, captured_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [DIGITS-1:0]   dv_q, dv_d;
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;

  logic                sel_onehot;
  logic                same_pair;
  logic                run_break;
  logic                capture;
  logic                glyph_legal;
  logic                glyph_blank;
  logic [3:0]          glyph_val;

  // Glyph decode works on the sampled pattern, so capture never depends on the live inputs.
  always_comb begin
    glyph_legal = 1'b1;
    glyph_blank = 1'b0;
    glyph_val   = 4'h0;
    case (seg_q)
      7'b1111110: glyph_val = 4'h0;
      7'b0110000: glyph_val = 4'h1;
      7'b1101101: glyph_val = 4'h2;
      7'b1111001: glyph_val = 4'h3;
      7'b0110011: glyph_val = 4'h4;
      7'b1011011: glyph_val = 4'h5;
      7'b1011111: glyph_val = 4'h6;
      7'b1110000: glyph_val = 4'h7;
      7'b1111111: glyph_val = 4'h8;
      7'b1111011: glyph_val = 4'h9;
      7'b1110111: glyph_val = 4'hA;
      7'b0011111: glyph_val = 4'hB;
      7'b1001110: glyph_val = 4'hC;
      7'b0111101: glyph_val = 4'hD;
      7'b1001111: glyph_val = 4'hE;
      7'b1000111: glyph_val = 4'hF;
      7'b0000000: begin
        glyph_legal = 1'b0;
        glyph_blank = 1'b1;
      end
      default:    glyph_legal = 1'b0;
    endcase
  end

  always_comb begin
    sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    same_pair  = (seg_in == seg_q) && (dig_sel == sel_q);
    run_break  = !sel_onehot || !same_pair;

    if (!sel_onehot) begin
      cnt_d = 4'd0;
    end else if (!same_pair) begin
      cnt_d = 4'd1;
    end else if (cnt_q == STABLE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end

    // A nonzero count implies sel_q is one-hot, so capture always targets exactly one digit.
    capture    = (cnt_q == STABLE) && !captured_q;
    captured_d = run_break ? 1'b0 : (captured_q || capture);
  end

  always_comb begin
    hex_d   = hex_q;
    dv_d    = dv_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
    err_d   = err_clr ? 1'b0 : err_q;

    if (capture) begin
      if (glyph_legal || glyph_blank) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel_q[i]) begin
            hex_d[4*i +: 4] = glyph_blank ? 4'h0 : glyph_val;
            dv_d[i]         = glyph_legal;
            mask_d[i]       = 1'b1;
          end
        end
        // The completing digit is consumed by this frame, so the mask restarts empty.
        if (&mask_d) begin
          frame_d = 1'b1;
          mask_d  = '0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      mask_q     <= '0;
      dv_q       <= '0;
      hex_q      <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      seg_q      <= seg_in;
      sel_q      <= dig_sel;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      mask_q     <= mask_d;
      dv_q       <= dv_d;
      hex_q      <= hex_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = dv_q;
  assign frame_valid = frame_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed vector table, hand sequences and random runs against a history-based model.
module tb_seg7_scan_decoder;
  localparam int DIGITS = 4;
  localparam int S      = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        err_clr;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel), .err_clr(err_clr),
    .hex_out(hex_out), .digit_valid(digit_valid), .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  logic [6:0] glyph [16];

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
  } pair_t;

  pair_t       hist[$];
  logic [15:0] m_hex;
  logic [3:0]  m_dv, m_mask;
  logic        m_frame, m_err;

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    int          hold;
    logic        clr;
    logic [15:0] hex;
    logic [3:0]  dv;
    logic        er;
    int          frames;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_onehot(input logic [3:0] s);
    int c = 0;
    for (int k = 0; k < 4; k++) if (s[k]) c++;
    return c == 1;
  endfunction

  // Capture at this edge iff the previous S sampled pairs are one identical one-hot pair
  // and the pair before them (if any since reset) was different.
  task automatic model_edge();
    pair_t cur, p;
    bit    cap, set_err;
    int    n, d, v;
    cur.sel = dig_sel;
    cur.seg = seg_in;
    m_frame = 1'b0;
    if (reset) begin
      hist.delete();
      m_hex = '0; m_dv = '0; m_mask = '0; m_err = 1'b0;
      return;
    end
    n = hist.size();
    cap = 1'b0;
    set_err = 1'b0;
    p = '0;
    if (n >= S) begin
      p = hist[n-1];
      cap = is_onehot(p.sel);
      for (int j = 1; j <= S; j++) if (hist[n-j] != p) cap = 1'b0;
      if (n > S && hist[n-S-1] == p) cap = 1'b0;
    end
    if (cap) begin
      d = 0;
      for (int k = 0; k < 4; k++) if (p.sel[k]) d = k;
      v = -1;
      for (int k = 0; k < 16; k++) if (glyph[k] == p.seg) v = k;
      if (p.seg == 7'd0) begin
        m_hex[4*d +: 4] = 4'h0; m_dv[d] = 1'b0; m_mask[d] = 1'b1;
      end else if (v >= 0) begin
        m_hex[4*d +: 4] = 4'(v); m_dv[d] = 1'b1; m_mask[d] = 1'b1;
      end else begin
        set_err = 1'b1;
      end
      if (!set_err && m_mask == 4'hF) begin
        m_frame = 1'b1;
        m_mask  = 4'h0;
      end
    end
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    hist.push_back(cur);
    if (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("hex_out", 32'(hex_out), 32'(m_hex));
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("frame_valid", 32'(frame_valid), 32'(m_frame));
    chk("err", 32'(err), 32'(m_err));
    if (frame_valid === 1'b1) frames++;
  endtask

  task automatic add(input logic [3:0] sel, input logic [6:0] seg, input int hold, input logic clr,
                     input logic [15:0] hex, input logic [3:0] dv, input logic er, input int fr);
    vec_t v;
    v.sel = sel; v.seg = seg; v.hold = hold; v.clr = clr;
    v.hex = hex; v.dv = dv; v.er = er; v.frames = fr;
    vt.push_back(v);
  endtask

  initial begin
    logic [6:0] scan [4];
    glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    scan = '{7'b1111111, 7'b0011111, 7'b1001110, 7'b1000111};

    reset = 1'b1; err_clr = 1'b0; seg_in = '0; dig_sel = '0;
    tick(); tick();
    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_dv", 32'(digit_valid), 32'h0);
    chk("rst_frame", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b0;

    add(4'b0001, 7'b1111001, 8, 1'b0, 16'h0003, 4'b0001, 1'b0, 0);
    add(4'b0010, 7'b1110111, 3, 1'b0, 16'h0003, 4'b0001, 1'b0, 0);
    add(4'b0010, 7'b0110000, 2, 1'b0, 16'h0003, 4'b0001, 1'b0, 0);
    add(4'b0010, 7'b1110111, 5, 1'b0, 16'h00A3, 4'b0011, 1'b0, 0);
    add(4'b0100, 7'b1010101, 5, 1'b0, 16'h00A3, 4'b0011, 1'b1, 0);
    add(4'b0100, 7'b1010101, 2, 1'b1, 16'h00A3, 4'b0011, 1'b0, 0);
    add(4'b0000, 7'b0000000, 1, 1'b0, 16'h00A3, 4'b0011, 1'b0, 0);
    add(4'b0100, 7'b1010101, 4, 1'b0, 16'h00A3, 4'b0011, 1'b0, 0);
    add(4'b0100, 7'b1010101, 1, 1'b1, 16'h00A3, 4'b0011, 1'b1, 0);
    add(4'b0001, 7'b0000000, 5, 1'b1, 16'h00A0, 4'b0010, 1'b0, 0);
    add(4'b0100, 7'b1111111, 5, 1'b0, 16'h08A0, 4'b0110, 1'b0, 0);
    add(4'b1000, 7'b1000111, 5, 1'b0, 16'hF8A0, 4'b1110, 1'b0, 1);
    add(4'b0011, 7'b1111111, 8, 1'b0, 16'hF8A0, 4'b1110, 1'b0, 0);
    add(4'b0001, 7'b1111111, 5, 1'b0, 16'hF8A8, 4'b1111, 1'b0, 0);
    add(4'b0010, 7'b0110000, 5, 1'b0, 16'hF818, 4'b1111, 1'b0, 0);
    add(4'b0001, 7'b1111111, 5, 1'b0, 16'hF818, 4'b1111, 1'b0, 0);
    add(4'b0100, 7'b1101101, 5, 1'b0, 16'hF218, 4'b1111, 1'b0, 0);
    add(4'b1000, 7'b1111001, 5, 1'b0, 16'h3218, 4'b1111, 1'b0, 1);

    foreach (vt[r]) begin
      frames  = 0;
      dig_sel = vt[r].sel;
      seg_in  = vt[r].seg;
      err_clr = vt[r].clr;
      repeat (vt[r].hold) tick();
      chk($sformatf("row%0d_hex", r), 32'(hex_out), 32'(vt[r].hex));
      chk($sformatf("row%0d_dv", r), 32'(digit_valid), 32'(vt[r].dv));
      chk($sformatf("row%0d_err", r), 32'(err), 32'(vt[r].er));
      chk($sformatf("row%0d_frames", r), 32'(frames), 32'(vt[r].frames));
    end
    err_clr = 1'b0;

    // Two full scans from reset: one frame pulse per scan.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      frames = 0;
      for (int d = 0; d < 4; d++) begin
        dig_sel = 4'(1 << d);
        seg_in  = scan[d];
        repeat (6) tick();
      end
      chk($sformatf("scan%0d_frames", rep), 32'(frames), 32'd1);
      chk($sformatf("scan%0d_hex", rep), 32'(hex_out), 32'hFCB8);
      chk($sformatf("scan%0d_dv", rep), 32'(digit_valid), 32'hF);
    end

    // Reset in the middle of a run discards it.
    dig_sel = 4'b0001; seg_in = 7'b1011011;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_hex", 32'(hex_out), 32'h0);
    chk("midrst_dv", 32'(digit_valid), 32'h0);
    repeat (4) tick();
    chk("postrst_nocap", 32'(hex_out), 32'h0);
    tick();
    chk("postrst_cap_hex", 32'(hex_out), 32'h0005);
    chk("postrst_cap_dv", 32'(digit_valid), 32'h1);

    // Random runs, including non-one-hot selects, illegal glyphs, err_clr and resets.
    for (int seg_n = 0; seg_n < 300; seg_n++) begin
      int hold, pick;
      if ($urandom_range(0, 7) == 0) dig_sel = 4'($urandom);
      else dig_sel = 4'(1 << $urandom_range(0, 3));
      pick = $urandom_range(0, 9);
      if (pick < 6) seg_in = glyph[$urandom_range(0, 15)];
      else if (pick == 6) seg_in = 7'd0;
      else if (pick == 7) seg_in = 7'($urandom);
      else seg_in = glyph[$urandom_range(0, 15)];
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        err_clr = ($urandom_range(0, 7) == 0);
        reset   = ($urandom_range(0, 119) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
